// File: rtl/chi5_hn_pkg.sv
// chi5_hn_pkg: shared opcodes, tracker entry type and routing-exemption helper
package chi5_hn_pkg;
  localparam int NID_MAX = 11;
  localparam int TXN_MAX = 12;
  localparam int DLY_W = 4;
  localparam logic [5:0] OP_EOBARRIER = 6'h0E;
  localparam logic [5:0] OP_ECBARRIER = 6'h0F;
  localparam logic [5:0] OP_DVMOP = 6'h14;
  localparam logic [3:0] COMP = 4'h4;
  typedef struct packed {
    logic [NID_MAX-1:0] srcid;
    logic [TXN_MAX-1:0] txnid;
    logic [DLY_W-1:0] delay;
  } trk_entry_t;
  function automatic logic tgt_exempt(input logic [5:0] op);
    return op inside {OP_EOBARRIER, OP_ECBARRIER, OP_DVMOP};
  endfunction
endpackage

// File: rtl/chi5_hn_trk_fifo.sv
// chi5_hn_trk_fifo: in-order tracker storage with per-entry Comp delay counters
module chi5_hn_trk_fifo
  import chi5_hn_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  trk_entry_t    push_entry,
  input  logic          pop,
  output logic          full,
  output logic          head_ready,
  output trk_entry_t    head_entry,
  output logic [PW-1:0] head_idx
);
  trk_entry_t mem_q [DEPTH];
  trk_entry_t mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign full = cnt_q == CW'(DEPTH);
  assign head_entry = mem_q[rd_q];
  assign head_ready = (cnt_q != '0) && (mem_q[rd_q].delay == '0);
  assign head_idx = rd_q;
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++)
      if (mem_q[i].delay != '0) mem_d[i].delay = mem_q[i].delay - DLY_W'(1);
    if (push) mem_d[wr_q] = push_entry;
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/chi5_hn_comp_responder.sv
// chi5_hn_comp_responder: HN-side REQ target that checks routing and returns delayed in-order Comp responses
module chi5_hn_comp_responder
  import chi5_hn_pkg::*;
#(
  parameter int NODE_ID_WIDTH = 7,
  parameter int TXNID_WIDTH = 8,
  parameter int NODE_ID = 0,
  parameter int DEPTH = 4,
  parameter int COMP_DELAY = 2
) (
  input  logic                     SCLK,
  input  logic                     SRESETn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NODE_ID_WIDTH-1:0] req_srcid,
  input  logic [NODE_ID_WIDTH-1:0] req_tgtid,
  input  logic [TXNID_WIDTH-1:0]   req_txnid,
  input  logic [5:0]               req_opcode,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NODE_ID_WIDTH-1:0] rsp_tgtid,
  output logic [NODE_ID_WIDTH-1:0] rsp_srcid,
  output logic [TXNID_WIDTH-1:0]   rsp_txnid,
  output logic [TXNID_WIDTH-1:0]   rsp_dbid,
  output logic [3:0]               rsp_opcode,
  output logic                     err_misroute,
  output logic [7:0]               misroute_cnt
);
  localparam int PW = $clog2(DEPTH);
  logic full, head_ready, routed, req_hs, rsp_hs;
  logic err_misroute_q, err_misroute_d;
  logic [7:0] misroute_cnt_q, misroute_cnt_d;
  logic [PW-1:0] head_idx;
  trk_entry_t push_entry, head_entry;
  logic unused_head;
  assign req_ready = SRESETn && !full;
  assign req_hs = req_valid && req_ready;
  assign routed = tgt_exempt(req_opcode) || (req_tgtid == NODE_ID_WIDTH'(NODE_ID));
  assign rsp_valid = head_ready;
  assign rsp_hs = rsp_valid && rsp_ready;
  assign push_entry = '{srcid: NID_MAX'(req_srcid), txnid: TXN_MAX'(req_txnid), delay: DLY_W'(COMP_DELAY)};
  assign rsp_tgtid = rsp_valid ? head_entry.srcid[NODE_ID_WIDTH-1:0] : '0;
  assign rsp_srcid = rsp_valid ? NODE_ID_WIDTH'(NODE_ID) : '0;
  assign rsp_txnid = rsp_valid ? head_entry.txnid[TXNID_WIDTH-1:0] : '0;
  assign rsp_dbid = rsp_valid ? TXNID_WIDTH'(head_idx) : '0;
  assign rsp_opcode = rsp_valid ? COMP : '0;
  assign unused_head = ^head_entry;
  assign err_misroute = err_misroute_q;
  assign misroute_cnt = misroute_cnt_q;
  chi5_hn_trk_fifo #(.DEPTH(DEPTH)) u_trk (
    .clk(SCLK),
    .rst_n(SRESETn),
    .push(req_hs && routed),
    .push_entry(push_entry),
    .pop(rsp_hs),
    .full(full),
    .head_ready(head_ready),
    .head_entry(head_entry),
    .head_idx(head_idx)
  );
  always_comb begin
    err_misroute_d = req_hs && !routed;
    misroute_cnt_d = (err_misroute_d && misroute_cnt_q != 8'hFF) ? misroute_cnt_q + 8'd1 : misroute_cnt_q;
  end
  always_ff @(posedge SCLK) begin
    if (!SRESETn) begin
      err_misroute_q <= 1'b0;
      misroute_cnt_q <= '0;
    end else begin
      err_misroute_q <= err_misroute_d;
      misroute_cnt_q <= misroute_cnt_d;
    end
  end
endmodule

// File: tb/tb_chi5_hn_comp_responder.sv
// tb_chi5_hn_comp_responder: vector table, directed corner sequences and random traffic against a queue-based model
module tb_chi5_hn_comp_responder;
  localparam int NID = 5;
  localparam int DEPTH = 4;
  localparam int DLY = 2;
  logic SCLK = 1'b0;
  logic SRESETn = 1'b0;
  logic req_valid = 1'b0;
  logic rsp_ready = 1'b0;
  logic [6:0] req_srcid = '0;
  logic [6:0] req_tgtid = '0;
  logic [7:0] req_txnid = '0;
  logic [5:0] req_opcode = '0;
  logic req_ready, rsp_valid, err_misroute;
  logic [6:0] rsp_tgtid, rsp_srcid;
  logic [7:0] rsp_txnid, rsp_dbid, misroute_cnt;
  logic [3:0] rsp_opcode;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  typedef struct {int src; int txn; int due; int slot;} ent_t;
  ent_t q[$];
  int wslot = 0;
  int mcnt = 0;
  logic merr = 1'b0;
  logic stall_q = 1'b0;
  logic [29:0] held = '0;
  typedef struct {
    logic [5:0] op;
    logic [6:0] src;
    logic [6:0] tgt;
    logic [7:0] txn;
    logic       err;
    logic [7:0] dbid;
  } vec_t;
  vec_t vec[8];

  always #5 SCLK = ~SCLK;

  chi5_hn_comp_responder #(
    .NODE_ID_WIDTH(7), .TXNID_WIDTH(8), .NODE_ID(NID), .DEPTH(DEPTH), .COMP_DELAY(DLY)
  ) dut (
    .SCLK(SCLK), .SRESETn(SRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_srcid(req_srcid), .req_tgtid(req_tgtid),
    .req_txnid(req_txnid), .req_opcode(req_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tgtid(rsp_tgtid), .rsp_srcid(rsp_srcid),
    .rsp_txnid(rsp_txnid), .rsp_dbid(rsp_dbid), .rsp_opcode(rsp_opcode),
    .err_misroute(err_misroute), .misroute_cnt(misroute_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exempt(input logic [5:0] op);
    return op == 6'h0E || op == 6'h0F || op == 6'h14;
  endfunction

  task automatic tick();
    logic ev, rdy;
    logic [29:0] cur;
    #1;
    ev = q.size() > 0 && q[0].due <= cyc;
    rdy = q.size() < DEPTH;
    chk("req_ready", req_ready, SRESETn && rdy);
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_tgtid", rsp_tgtid, ev ? q[0].src : 0);
    chk("rsp_srcid", rsp_srcid, ev ? NID : 0);
    chk("rsp_txnid", rsp_txnid, ev ? q[0].txn : 0);
    chk("rsp_dbid", rsp_dbid, ev ? q[0].slot : 0);
    chk("rsp_opcode", rsp_opcode, ev ? 4 : 0);
    chk("err_misroute", err_misroute, merr);
    chk("misroute_cnt", misroute_cnt, mcnt);
    cur = {rsp_tgtid, rsp_srcid, rsp_txnid, rsp_dbid};
    if (stall_q) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_fields", cur, held);
    end
    stall_q = SRESETn && rsp_valid && !rsp_ready;
    held = cur;
    if (!SRESETn) begin
      q.delete();
      wslot = 0;
      mcnt = 0;
      merr = 1'b0;
    end else begin
      if (ev && rsp_ready) void'(q.pop_front());
      merr = 1'b0;
      if (req_valid && rdy) begin
        if (exempt(req_opcode) || req_tgtid == 7'(NID)) begin
          q.push_back('{int'(req_srcid), int'(req_txnid), cyc + 1 + DLY, wslot});
          wslot = (wslot + 1) % DEPTH;
        end else begin
          merr = 1'b1;
          if (mcnt < 255) mcnt++;
        end
      end
    end
    @(posedge SCLK);
    @(negedge SCLK);
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int seen, acc, got, stale;
    logic acc_now;
    vec[0] = '{6'h01, 7'h02, 7'h05, 8'h33, 1'b0, 8'd0};
    vec[1] = '{6'h01, 7'h02, 7'h06, 8'h33, 1'b1, 8'd0};
    vec[2] = '{6'h14, 7'h03, 7'h09, 8'h44, 1'b0, 8'd1};
    vec[3] = '{6'h0E, 7'h7F, 7'h00, 8'hA5, 1'b0, 8'd2};
    vec[4] = '{6'h0F, 7'h01, 7'h7F, 8'h00, 1'b0, 8'd3};
    vec[5] = '{6'h1D, 7'h04, 7'h04, 8'h01, 1'b1, 8'd0};
    vec[6] = '{6'h15, 7'h06, 7'h00, 8'h02, 1'b1, 8'd0};
    vec[7] = '{6'h0D, 7'h06, 7'h05, 8'hFF, 1'b0, 8'd0};
    @(posedge SCLK);
    @(negedge SCLK);
    tick();
    SRESETn = 1'b1;
    #1;
    chk("ready_after_release", req_ready, 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_opcode = vec[i].op;
      req_srcid = vec[i].src;
      req_tgtid = vec[i].tgt;
      req_txnid = vec[i].txn;
      tick();
      req_valid = 1'b0;
      seen = 0;
      for (int k = 1; k <= DLY + 3; k++) begin
        #1;
        if (k == 1) chk("vec_err", err_misroute, vec[i].err);
        if (rsp_valid && seen == 0) begin
          seen = 1;
          chk("vec_latency", k, DLY + 1);
          chk("vec_tgtid", rsp_tgtid, vec[i].src);
          chk("vec_txnid", rsp_txnid, vec[i].txn);
          chk("vec_dbid", rsp_dbid, vec[i].dbid);
        end
        tick();
      end
      chk("vec_rsp_seen", seen, !vec[i].err);
    end
    req_valid = 1'b1;
    req_opcode = 6'h01;
    req_tgtid = 7'h06;
    for (int k = 0; k < 300; k++) tick();
    req_valid = 1'b0;
    #1;
    chk("sat_cnt", misroute_cnt, 255);
    tick();
    SRESETn = 1'b0;
    tick();
    SRESETn = 1'b1;
    rsp_ready = 1'b0;
    acc = 0;
    req_srcid = 7'h11;
    req_tgtid = 7'(NID);
    req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_txnid = 8'(8'h10 + acc);
      #1;
      if (req_ready) acc++;
      tick();
    end
    #1;
    chk("fill_accepted", acc, 4);
    chk("fill_full_ready", req_ready, 0);
    rsp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 40 && got < 5; k++) begin
      #1;
      if (rsp_valid) begin
        chk("fill_txnid", rsp_txnid, 8'h10 + got);
        chk("fill_dbid", rsp_dbid, got % 4);
        got++;
      end
      if (req_valid && req_ready) acc++;
      tick();
      if (acc == 5) req_valid = 1'b0;
    end
    chk("fill_comps", got, 5);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_txnid = 8'(8'h60 + k);
      tick();
    end
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    SRESETn = 1'b0;
    tick();
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    SRESETn = 1'b1;
    #1;
    chk("rst_release_ready", req_ready, 1);
    rsp_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (rsp_valid) stale++;
      tick();
    end
    chk("rst_no_stale", stale, 0);
    acc_now = 1'b1;
    for (int k = 0; k < 500; k++) begin
      if (!req_valid || acc_now) begin
        int r;
        r = $urandom_range(0, 7);
        req_valid = 1'($urandom_range(0, 1));
        req_opcode = r == 0 ? 6'h0E : r == 1 ? 6'h0F : r == 2 ? 6'h14 : 6'($urandom_range(0, 63));
        req_tgtid = $urandom_range(0, 3) == 0 ? 7'($urandom) : 7'(NID);
        req_srcid = 7'($urandom);
        req_txnid = 8'($urandom);
      end
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      acc_now = req_valid && req_ready;
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
